rf_scoreboard: RTL and testbench
================================

# rf_scoreboard

Register scoreboard for the pipelined core's 32×32 register file. It tracks in-flight writes to each architectural register and holds issue (`iss_ready` low) on RAW hazards and on write-count overflow. It sits between decode/issue and the register file read ports and retires entries when writeback reaches the RF write port. It also counts stall cycles and flags bookkeeping errors.

## Interface
- `NREG`, 32, number of architectural registers; r0 is hardwired zero and never tracked
- `CNT_W`, 2, width of the per-register in-flight counter; max outstanding writes per register is 2^CNT_W−1
- `STALL_W`, 16, width of the stall performance counter

- `clk` in 1: single clock, all state on rising edge
- `rstn` in 1: reset, synchronous, active-low
- `iss_valid` in 1: decode presents an instruction
- `iss_ready` out 1: instruction may issue this cycle
- `iss_rs1`, `iss_rs2` in 5: source register indices (A1/A2 of the RF)
- `iss_rd` in 5: destination index
- `iss_rd_we` in 1: instruction writes `iss_rd`
- `wb_valid` in 1: writeback commits to RF this cycle (RFWr)
- `wb_rd` in 5: writeback destination (A3 of the RF)
- `flush` in 1: pipeline flush, discards all in-flight tracking
- `busy_mask` out NREG: bit i = register i has ≥1 outstanding write; bit 0 always 0
- `stall_cnt` out STALL_W: saturating count of stalled issue cycles
- `sb_err` out 1: sticky error flag

## Operation
- State: counters `cnt[1..NREG-1]`, `stall_cnt`, `sb_err`. No other FSM.
- Hazard is the OR of:
  - `cnt[iss_rs1]!=0` (rs1≠0)
  - `cnt[iss_rs2]!=0` (rs2≠0)
  - `iss_rd_we && iss_rd!=0 && cnt[iss_rd]==MAX` (overflow guard)
- `iss_ready = rstn && !flush && !hazard`. It is combinational and does not depend on `iss_valid`.
- Accept = `iss_valid && iss_ready`.
- Accept with `iss_rd_we` and rd≠0: `cnt[rd]` +1. rd=0 writes are never tracked.
- `wb_valid` with wb_rd≠0 and `cnt[wb_rd]!=0`: `cnt[wb_rd]` −1.
- Same register incremented and decremented in one cycle: net unchanged.
- `wb_valid` to a register with cnt=0: counter stays 0 and `sb_err` is set. `wb_rd=0` is ignored and is not an error.
- `flush`:
  - Highest priority; all counters are 0 next cycle.
  - The same-cycle accept is blocked and the same-cycle writeback is ignored. No error is raised.
- `stall_cnt` +1 each cycle with `iss_valid && !iss_ready && !flush`. It saturates at all-ones.
- `sb_err` is cleared only by reset.
- `busy_mask[i] = (cnt[i]!=0)`, decoded directly from the counter registers.

## Timing
- Reset (`rstn`=0 at a rising edge): all counters 0, `busy_mask`=0, `stall_cnt`=0, `sb_err`=0. `iss_ready`=0 while `rstn` is low.
- Reset mid-operation discards all in-flight state; any later writebacks of old instructions are flagged as `sb_err`.
- Accept at edge N: `busy_mask[rd]`=1 from cycle N+1, and dependent sources stall from cycle N+1.
- Writeback at edge N with cnt=1: `busy_mask` clears from N+1. Without the bypass option, the dependent instruction issues at N+1 at the earliest.
- Zero-latency `iss_ready`; no internal buffering.

## Configuration
- `RF_SB_WB_BYPASS_EN` defined: a source hazard is ignored when `wb_valid && wb_rd==src && cnt[src]==1`. The RF writes on the falling edge, so the read data is valid before the issuing rising edge. The dependent instruction therefore issues in the writeback cycle.
- Undefined: no bypass; the source stalls until the counter is 0 at the registered state.
- The overflow guard and `sb_err` are unaffected by the macro.

## Structure
- Package `rf_sb_pkg` contains:
  - `REG_IDX_W=5`, `NREG`, `CNT_W` and `CNT_MAX`
  - typedef `reg_idx_t` (logic [4:0]) and typedef `sb_cnt_t`
- Sub-module `rf_sb_counter`: one per-register up/down counter.
  - Inputs: inc, dec, clr. Output: busy.
  - Generated for indices 1..NREG−1.
- Top level owns hazard decode, `stall_cnt` and `sb_err`.

## Test plan
- **Reset:** rstn=0 for 2 cycles → `busy_mask`=0, `stall_cnt`=0, `sb_err`=0, `iss_ready`=0. Release → `iss_ready`=1.
- **RAW stall:** issue rd=5, then rs1=5 → `iss_ready`=0 and `stall_cnt` +1 per cycle. `wb_valid`, `wb_rd`=5 → issue accepted at the next cycle, or in the same cycle with `RF_SB_WB_BYPASS_EN`.
- **Overflow:** three issues to rd=7 with no writeback → `busy_mask[7]`=1. Fourth issue to rd=7 stalls; one writeback to 7 → fourth accepted.
- **Simultaneous:** cnt[3]=1; accept rd=3 and writeback wb_rd=3 in the same cycle → `busy_mask[3]` stays 1 and cnt stays 1. A second writeback clears it.
- **Flush:** cnt[4]=2, cnt[9]=1, then flush together with `iss_valid` → no accept and `busy_mask`=0 next cycle. A later writeback to 4 sets `sb_err`=1, which stays set until reset.
- **r0 and saturation:** issue rd=0 and writeback wb_rd=0 → no change and no error. Hold a stall for 70000 cycles → `stall_cnt`=0xFFFF.

Source files
------------

// File: rtl/rf_sb_pkg.sv
// Shared types and sizing for the register-file scoreboard.
package rf_sb_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NREG      = 32;
  localparam int CNT_W     = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]     sb_cnt_t;
endpackage

// File: rtl/rf_sb_counter.sv
// Per-register in-flight write counter; clr wins, inc and dec together cancel.
module rf_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);
endmodule

// File: rtl/rf_scoreboard.sv
// Register scoreboard: RAW / overflow issue hold, stall counter, sticky error.
// Optional macro RF_SB_WB_BYPASS_EN lets a source issue in its writeback cycle.
module rf_scoreboard import rf_sb_pkg::*; #(
  parameter int NREG    = 32,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  reg_idx_t           iss_rs1,
  input  reg_idx_t           iss_rs2,
  input  reg_idx_t           iss_rd,
  input  logic               iss_rd_we,
  input  logic               wb_valid,
  input  reg_idx_t           wb_rd,
  input  logic               flush,
  output logic [NREG-1:0]    busy_mask,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               sb_err
);
  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

  logic [NREG-1:0][CNT_W-1:0] cnt_s;
  logic rs1_haz_s, rs2_haz_s, ovf_haz_s, ready_s, accept_s, wb_hit_s, wb_err_s;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic sb_err_q, sb_err_d;

  assign cnt_s[0]     = '0;
  assign busy_mask[0] = 1'b0;

  always_comb begin
    rs1_haz_s = (iss_rs1 != REG_IDX_W'(0)) && (cnt_s[iss_rs1] != '0);
    rs2_haz_s = (iss_rs2 != REG_IDX_W'(0)) && (cnt_s[iss_rs2] != '0);
`ifdef RF_SB_WB_BYPASS_EN
    // RF writes on the falling edge, so the last pending write is readable now
    if (wb_valid && (wb_rd == iss_rs1) && (cnt_s[iss_rs1] == CNT_W'(1))) begin
      rs1_haz_s = 1'b0;
    end else begin
      rs1_haz_s = rs1_haz_s;
    end
    if (wb_valid && (wb_rd == iss_rs2) && (cnt_s[iss_rs2] == CNT_W'(1))) begin
      rs2_haz_s = 1'b0;
    end else begin
      rs2_haz_s = rs2_haz_s;
    end
`endif
    ovf_haz_s = iss_rd_we && (iss_rd != REG_IDX_W'(0)) && (cnt_s[iss_rd] == CNT_FULL);
    ready_s   = rstn && !flush && !(rs1_haz_s || rs2_haz_s || ovf_haz_s);
    accept_s  = iss_valid && ready_s;
    wb_hit_s  = wb_valid && !flush && (wb_rd != REG_IDX_W'(0));
    wb_err_s  = wb_hit_s && (cnt_s[wb_rd] == '0);
  end

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    rf_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (accept_s && iss_rd_we && (iss_rd == REG_IDX_W'(i))),
      .dec  (wb_hit_s && (wb_rd == REG_IDX_W'(i)) && (cnt_s[i] != '0)),
      .clr  (flush),
      .cnt  (cnt_s[i]),
      .busy (busy_mask[i])
    );
  end

  always_comb begin
    stall_d  = stall_q;
    sb_err_d = sb_err_q | wb_err_s;
    if (iss_valid && !ready_s && !flush && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q  <= '0;
      sb_err_q <= 1'b0;
    end else begin
      stall_q  <= stall_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign iss_ready = ready_s;
  assign stall_cnt = stall_q;
  assign sb_err    = sb_err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Scoreboard-driven bench for rf_scoreboard with a behavioural reference model.
module tb_rf_scoreboard;
  logic        clk = 1'b0;
  logic        rstn, iss_valid, iss_ready, iss_rd_we, wb_valid, flush, sb_err;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd, wb_rd;
  logic [31:0] busy_mask;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  rf_scoreboard dut (
    .clk(clk), .rstn(rstn), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy_mask(busy_mask),
    .stall_cnt(stall_cnt), .sb_err(sb_err)
  );

  typedef struct {
    logic        ready;
    logic [31:0] busy;
    logic [15:0] stall;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt[32];
  int   m_stall = 0;
  bit   m_err = 1'b0;
`ifdef RF_SB_WB_BYPASS_EN
  bit   byp = 1'b1;
`else
  bit   byp = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit src_busy(input int r, input bit wbv, input int wbrd);
    return (r != 0) && (mcnt[r] != 0) && !(byp && wbv && (wbrd == r) && (mcnt[r] == 1));
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'd0;
    for (int i = 1; i < 32; i++) m[i] = (mcnt[i] != 0);
    return m;
  endfunction

  // One clock: drive, predict, sample ready, then compare registered outputs after the edge.
  task automatic cyc(input bit v, input int rs1, input int rs2, input int rd, input bit we,
                     input bit wbv, input int wbrd, input bit fl, input bit rst_n);
    bit   haz, rdy;
    logic got_rdy;
    exp_t e, o;
    iss_valid = v; iss_rs1 = 5'(rs1); iss_rs2 = 5'(rs2); iss_rd = 5'(rd);
    iss_rd_we = we; wb_valid = wbv; wb_rd = 5'(wbrd); flush = fl; rstn = rst_n;
    #1;
    haz = src_busy(rs1, wbv, wbrd) || src_busy(rs2, wbv, wbrd) ||
          (we && (rd != 0) && (mcnt[rd] == 3));
    rdy = rst_n && !fl && !haz;
    got_rdy = iss_ready;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
      m_stall = 0;
      m_err = 1'b0;
    end else if (fl) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      if (wbv && (wbrd != 0)) begin
        if (mcnt[wbrd] == 0) m_err = 1'b1;
        else mcnt[wbrd]--;
      end
      if (v && rdy && we && (rd != 0)) mcnt[rd]++;
      if (v && !rdy && (m_stall < 65535)) m_stall++;
    end
    e.ready = rdy; e.busy = model_mask(); e.stall = 16'(m_stall); e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check_val("iss_ready", {31'd0, got_rdy}, {31'd0, o.ready});
    check_val("busy_mask", busy_mask, o.busy);
    check_val("stall_cnt", {16'd0, stall_cnt}, {16'd0, o.stall});
    check_val("sb_err", {31'd0, sb_err}, {31'd0, o.err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    // reset
    cyc(1, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(1);
    // RAW on rs1, then rs2
    cyc(1, 0, 0, 5, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 5, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 5, 0, 0, 0, 1, 5, 0, 1);
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 6, 1, 0, 0, 0, 1);
    cyc(1, 0, 6, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 6, 0, 0, 1, 6, 0, 1);
    cyc(1, 0, 6, 0, 0, 0, 0, 0, 1);
    // overflow on rd=7
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 7, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 7, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 7, 1, 1, 7, 0, 1);
    cyc(1, 0, 0, 7, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 7, 0, 1);
    // simultaneous inc/dec on r3
    cyc(1, 0, 0, 3, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 3, 1, 1, 3, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 3, 0, 1);
    // flush with live state, then a stale writeback
    cyc(1, 0, 0, 4, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 4, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 9, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 4, 1, 1, 9, 1, 1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 1, 4, 0, 1);
    idle(3);
    // r0 is never tracked and never errors
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 1);
    idle(1);
    // random traffic on a small register window
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 7), ($urandom_range(0, 19) == 0), 1);
    // reset clears sticky error, then saturate the stall counter
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 8, 1, 0, 0, 0, 1);
    iss_valid = 1'b1; iss_rs1 = 5'd8; iss_rs2 = 5'd0; iss_rd = 5'd0; iss_rd_we = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0; rstn = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    m_stall = (m_stall + 70000 > 65535) ? 65535 : m_stall + 70000;
    cyc(1, 8, 0, 0, 0, 0, 0, 0, 1);
    check_val("stall_sat", {16'd0, stall_cnt}, 32'h0000ffff);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
